bias_loader: RTL and testbench
==============================

# bias_loader

Writable counterpart of the constant bias ROM. It accepts a stream of 128 signed 32-bit bias words over a valid/ready handshake and writes them sequentially into an internal 128×32 memory. Once the memory is full, it serves four independent registered read lanes with the same packing as the bias ROM. It sits between the host/DMA weight stream and the accumulator stage, so biases can be reloaded per layer without resynthesis.

## Interface
Parameters:
- DEPTH, 128, number of bias entries.
- WIDTH, 32, bits per bias word (two's complement).
- LANES, 4, number of read lanes.
- AW, 7, address width (clog2(DEPTH)).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a (re)load.
- s_valid  in  1  stream word valid.
- s_data  in  WIDTH  stream bias word.
- s_ready  out  1  block accepts a word this cycle.
- a1, a2, a3, a4  in  AW  read addresses, lanes 0..3.
- bias  out  LANES*WIDTH  lane k at bias[32k+31:32k]; lane 0 = a1.
- loaded  out  1  memory holds a complete bias set.
- busy  out  1  load in progress.
- wr_count  out  AW+1  words accepted in the current load (0..128).

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start → LOAD.
  - LOAD: on each handshake (s_valid && s_ready), write s_data to mem[wr_ptr], then wr_ptr++ and wr_count++. The handshake that writes index DEPTH-1 → DONE.
  - DONE: start → LOAD, which clears wr_ptr and wr_count and drops loaded.
- start is ignored while in LOAD. The load is not restartable except via rst.
- s_ready = (state == LOAD). Combinational from state only; no dependency on s_valid.
- busy = (state == LOAD). loaded = (state == DONE).
- Read lanes: every cycle, bias lane k <= loaded ? mem[ak] : 0. Lanes are independent, and identical addresses on several lanes are legal.
- No arithmetic on data: words are stored and returned bit-exact, with sign preserved.
- s_data is ignored when no handshake occurs. Words offered outside LOAD are never accepted (s_ready=0).
- Because reads are gated by loaded, no read-during-write hazard exists.

## Timing
- Reset values: state=IDLE, s_ready=0, busy=0, loaded=0, wr_count=0, bias=0. Memory contents are not reset and are undefined until a load completes.
- start sampled at edge t puts the block in LOAD from t+1, so s_ready=1 in cycle t+1.
- Throughput is one word per cycle. A back-to-back full load takes 128 cycles of s_ready.
- Final handshake at edge u: s_ready=0 and loaded=1 from u+1.
- Read latency is 1 cycle. Addresses presented in cycle c appear on bias after edge c+1.
  - First valid bias is after edge u+2, for addresses presented in cycle u+1.
- Reload: start in DONE at edge t makes loaded=0 from t+1, so bias reads 0 from edge t+2 onward.
- Reset mid-load returns to IDLE immediately (asynchronous), with wr_count=0 and loaded=0. Partially written words remain in memory but are unreadable until a full load completes.
- start coincident with a handshake in LOAD: the handshake is processed and start is ignored.
- s_valid stalls (gaps) are allowed in LOAD; wr_ptr holds while s_valid is low.

## Structure
- Package bias_pkg holds:
  - DEPTH, WIDTH, LANES and AW constants;
  - state enum bias_state_t {IDLE, LOAD, DONE};
  - typedef bias_word_t (logic signed [WIDTH-1:0]).
- Sub-module bias_mem: 1 write port (we, waddr, wdata) and LANES registered read ports with a read-enable gate. The FSM, pointer and handshake live in bias_loader.

## Test plan
- Reset then idle: hold rst 3 cycles, release, and present a1..a4=0,1,2,3 for 5 cycles → bias=0, loaded=0, s_ready=0 throughout.
- Full load, continuous: pulse start, then stream words i → 0x1000+i for i=0..127 with s_valid held high → exactly 128 handshakes, and loaded=1 the cycle after the last one. Then a1..a4=0,5,127,64 → bias lanes after 1 cycle read 0x1000, 0x1005, 0x107F, 0x1040.
- Stalled load with negative values: stream 0xFFFFFC00−i with s_valid toggling pseudo-randomly → wr_count is monotonic and each entry matches. a1=a2=a3=a4=10 → all lanes read 0xFFFFFBF6.
- Extra and early words: assert s_valid with data before start, and a 129th word after the load completes → neither is accepted, and the contents match the 128-word set.
- Reload: after a full load, pulse start → loaded=0 and bias=0 two edges later. Loading 0xA5A50000+i → reads return the new values only.
- Reset mid-load: assert rst after 60 words → outputs return to reset values asynchronously. A new start followed by 128 words loads and reads back correctly.

Source files
------------

// File: rtl/bias_pkg.sv
// Shared constants and types for the reloadable bias memory.
// The read packing matches the constant bias ROM, so the accumulator stage sees no difference.
package bias_pkg;

    localparam int DEPTH = 128;
    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } bias_state_t;

    typedef logic signed [WIDTH-1:0] bias_word_t;

endpackage

// File: rtl/bias_mem.sv
// 128x32 bias storage with one write port and LANES independent registered read ports.
// A read-enable gate forces every lane to zero while the contents are not a complete set.
module bias_mem
    import bias_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  bias_word_t                   wdata,
    input  logic                         re,
    input  logic [LANES-1:0][AW-1:0]     raddr,
    output logic [LANES*WIDTH-1:0]       rdata
);

    bias_word_t mem [DEPTH];
    bias_word_t rd_d [LANES];
    bias_word_t rd_q [LANES];

    // Storage array is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rd_d[k] = re ? mem[raddr[k]] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < LANES; k++) begin
            rdata[k*WIDTH +: WIDTH] = rd_q[k];
        end
    end

endmodule

// File: rtl/bias_loader.sv
// Streams 128 bias words in over valid/ready, then serves them on four registered read lanes.
// Lets the host reload biases per layer while the accumulator sees ROM-compatible packing.
module bias_loader
    import bias_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [WIDTH-1:0]         s_data,
    output logic                     s_ready,
    input  logic [AW-1:0]            a1,
    input  logic [AW-1:0]            a2,
    input  logic [AW-1:0]            a3,
    input  logic [AW-1:0]            a4,
    output logic [LANES*WIDTH-1:0]   bias,
    output logic                     loaded,
    output logic                     busy,
    output logic [AW:0]              wr_count
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    bias_state_t state_q, state_d;
    logic [AW:0] wr_count_q, wr_count_d;
    logic        busy_q, busy_d;
    logic        loaded_q, loaded_d;
    logic        hs;

    assign s_ready  = (state_q == LOAD);
    assign hs       = s_valid && s_ready;
    assign busy     = busy_q;
    assign loaded   = loaded_q;
    assign wr_count = wr_count_q;

    // start is only honoured outside LOAD; a load in flight can only be abandoned by rst.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    wr_count_d = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    wr_count_d = wr_count_q + (AW+1)'(1);
                    if (wr_count_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    wr_count_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                wr_count_d = '0;
            end
        endcase
        busy_d   = (state_d == LOAD);
        loaded_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_count_q <= '0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            busy_q     <= busy_d;
            loaded_q   <= loaded_d;
        end
    end

    bias_mem u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (hs),
        .waddr (wr_count_q[AW-1:0]),
        .wdata (s_data),
        .re    (loaded_q),
        .raddr ({a4, a3, a2, a1}),
        .rdata (bias)
    );

endmodule

// File: tb/tb_bias_loader.sv
// Scoreboard bench for bias_loader: reads push expected lane data, a monitor pops and compares.
// Status outputs are checked directly against hand-derived values after each phase.
module tb_bias_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         s_valid;
    logic [31:0]  s_data;
    logic         s_ready;
    logic [6:0]   a1, a2, a3, a4;
    logic [127:0] bias;
    logic         loaded;
    logic         busy;
    logic [7:0]   wr_count;

    int vectors     = 0;
    int miscompares = 0;
    int hs_count    = 0;
    int hs_base     = 0;

    typedef struct {
        logic [127:0] exp;
        string        name;
    } rd_exp_t;

    rd_exp_t     sb_q[$];
    rd_exp_t     mon_e;
    logic        rd_issue   = 1'b0;
    logic [31:0] exp_mem [128];
    logic        exp_loaded = 1'b0;

    bias_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .a4       (a4),
        .bias     (bias),
        .loaded   (loaded),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Counts every accepted word so stray handshakes outside LOAD show up.
    always @(posedge clk) begin
        if (s_valid && s_ready) begin
            hs_count++;
        end
    end

    // Addresses seen at a rising edge produce bias data visible by the following falling edge.
    always begin
        @(posedge clk);
        if (rd_issue) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL sb_underflow: got read with no expectation, want queued entry");
            end else begin
                mon_e = sb_q.pop_front();
                check_output(mon_e.name, bias, mon_e.exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        rd_issue = 1'b0;
        start    = 1'b0;
    endtask

    task automatic issue_read(input logic [6:0] x1, input logic [6:0] x2,
                              input logic [6:0] x3, input logic [6:0] x4,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [31:0] e4,
                              input string nm);
        rd_exp_t e;
        a1 = x1;
        a2 = x2;
        a3 = x3;
        a4 = x4;
        rd_issue = 1'b1;
        e.exp  = {e4, e3, e2, e1};
        e.name = nm;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] model_word(input logic [6:0] a);
        return exp_loaded ? exp_mem[a] : 32'h0;
    endfunction

    task automatic apply_stimulus_read(input logic [6:0] x1, input logic [6:0] x2,
                                       input logic [6:0] x3, input logic [6:0] x4,
                                       input string nm);
        issue_read(x1, x2, x3, x4, model_word(x1), model_word(x2),
                   model_word(x3), model_word(x4), nm);
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 32; i++) begin
            apply_stimulus_read(7'(i), 7'(i + 32), 7'(i + 64), 7'(i + 96), nm);
            tick();
        end
        tick();
        tick();
    endtask

    // Streams 128 words base+idx (or base-idx); stall mode drops s_valid pseudo-randomly.
    task automatic load_words(input logic [31:0] base, input bit neg, input bit stall, input bit with_start);
        int          idx = 0;
        int          cyc = 0;
        logic        v;
        logic [31:0] val;
        if (with_start) begin
            start = 1'b1;
            tick();
            exp_loaded = 1'b0;
        end
        check_output("ready_in_load", 128'(s_ready), 128'(1));
        check_output("busy_in_load", 128'(busy), 128'(1));
        hs_base = hs_count;
        while (idx < 128 && cyc < 2000) begin
            v   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            val = neg ? (base - 32'(idx)) : (base + 32'(idx));
            s_valid = v;
            s_data  = v ? val : 32'h5A5A5A5A;
            tick();
            cyc++;
            if (v) begin
                exp_mem[idx] = val;
                idx++;
            end
            check_output("wr_count_step", 128'(wr_count), 128'(idx));
        end
        s_valid = 1'b0;
        exp_loaded = 1'b1;
        check_output("load_cycles", 128'(idx), 128'(128));
        check_output("loaded_after_last", 128'(loaded), 128'(1));
        check_output("ready_after_last", 128'(s_ready), 128'(0));
        check_output("busy_after_last", 128'(busy), 128'(0));
        check_output("wr_count_full", 128'(wr_count), 128'(128));
        check_output("handshakes", 128'(hs_count - hs_base), 128'(128));
    endtask

    task automatic check_reset_outputs(input string nm);
        check_output({nm, "_ready"}, 128'(s_ready), 128'(0));
        check_output({nm, "_busy"}, 128'(busy), 128'(0));
        check_output({nm, "_loaded"}, 128'(loaded), 128'(0));
        check_output({nm, "_wr_count"}, 128'(wr_count), 128'(0));
        check_output({nm, "_bias"}, bias, 128'(0));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        a4 = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle reads return zero and words offered before start are refused.
        s_valid = 1'b1;
        s_data  = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            issue_read(7'd0, 7'd1, 7'd2, 7'd3, 32'h0, 32'h0, 32'h0, 32'h0, "idle_read");
            tick();
            check_output("idle_loaded", 128'(loaded), 128'(0));
            check_output("idle_ready", 128'(s_ready), 128'(0));
        end
        tick();
        tick();
        check_output("idle_no_accept", 128'(hs_count), 128'(0));
        s_valid = 1'b0;

        load_words(32'h00001000, 1'b0, 1'b0, 1'b1);
        issue_read(7'd0, 7'd5, 7'd127, 7'd64,
                   32'h00001000, 32'h00001005, 32'h0000107F, 32'h00001040, "cont_read");
        tick();
        sweep("cont_sweep");

        load_words(32'hFFFFFC00, 1'b1, 1'b1, 1'b1);
        issue_read(7'd10, 7'd10, 7'd10, 7'd10,
                   32'hFFFFFBF6, 32'hFFFFFBF6, 32'hFFFFFBF6, 32'hFFFFFBF6, "neg_same_addr");
        tick();

        // A 129th word after completion must not be taken.
        hs_base = hs_count;
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        repeat (3) tick();
        s_valid = 1'b0;
        check_output("extra_no_accept", 128'(hs_count - hs_base), 128'(0));
        check_output("extra_wr_count", 128'(wr_count), 128'(128));
        check_output("extra_loaded", 128'(loaded), 128'(1));
        sweep("neg_sweep");

        // Reload: the read issued with start still sees old data, the next one sees zero.
        start = 1'b1;
        issue_read(7'd3, 7'd3, 7'd3, 7'd3,
                   32'hFFFFFBFD, 32'hFFFFFBFD, 32'hFFFFFBFD, 32'hFFFFFBFD, "reload_old");
        tick();
        exp_loaded = 1'b0;
        check_output("reload_loaded", 128'(loaded), 128'(0));
        check_output("reload_ready", 128'(s_ready), 128'(1));
        check_output("reload_wr_count", 128'(wr_count), 128'(0));
        issue_read(7'd3, 7'd3, 7'd3, 7'd3, 32'h0, 32'h0, 32'h0, 32'h0, "reload_zero");
        tick();
        load_words(32'hA5A50000, 1'b0, 1'b0, 1'b0);
        issue_read(7'd0, 7'd3, 7'd127, 7'd64,
                   32'hA5A50000, 32'hA5A50003, 32'hA5A5007F, 32'hA5A50040, "reload_read");
        tick();
        sweep("reload_sweep");

        // Reset asserted between clock edges after 60 words.
        start = 1'b1;
        tick();
        exp_loaded = 1'b0;
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h00007700 + 32'(i);
            tick();
        end
        check_output("midload_count", 128'(wr_count), 128'(60));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("post_reset");
        load_words(32'h00003000, 1'b0, 1'b0, 1'b1);
        sweep("post_reset_sweep");

        check_output("sb_drain", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
